dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 The block SHALL expose parameter DMEM_DEPTH, default 1024, number of 32-bit words in storage.
REQ-002 The block SHALL expose parameter DMEM_ADDR_WIDTH, default 10, word-index width, log2(DMEM_DEPTH).
REQ-003 The block SHALL expose parameter LATENCY, default 2, wait cycles between accept and response, legal range 0..15.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 reset_b  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  CPU memory-stage request present.
REQ-007 req_write  input  1  1 = store (sd), 0 = load (ld).
REQ-008 req_addr  input  32  byte address, ALU result of memory stage.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_ready  output  1  responder can accept a request this cycle.
REQ-011 resp_valid  output  1  one-cycle pulse, response complete.
REQ-012 resp_rdata  output  32  load data, valid while resp_valid=1.
REQ-013 resp_err  output  1  request faulted, valid while resp_valid=1.
REQ-014 busy  output  1  stall request to hazard unit.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 IDLE: req_ready=1; req_valid=1 SHALL accept the request, capturing write, addr, wdata into an internal request register.
REQ-017 On accept, next state SHALL be RESP if LATENCY=0, else WAIT with a 4-bit down-counter loaded with LATENCY-1.
REQ-018 WAIT: counter decrements each cycle; at counter=0 next state SHALL be RESP.
REQ-019 RESP: resp_valid=1 for exactly one cycle; next state SHALL be IDLE unconditionally.
REQ-020 Response latency SHALL be exactly LATENCY+1 cycles: accept at edge T, resp_valid high during cycle T+LATENCY+1.
REQ-021 req_ready SHALL be 0 in WAIT and RESP; req_valid in those states SHALL be ignored, with no queuing.
REQ-022 Maximum throughput SHALL be one request per LATENCY+2 cycles.
REQ-023 Word index SHALL be addr[DMEM_ADDR_WIDTH+1:2] of the captured address.
REQ-024 Error condition: addr[1:0]!=0, or addr[31:DMEM_ADDR_WIDTH+2]!=0.
REQ-025 On error: resp_err=1, resp_rdata=0, and storage SHALL NOT be modified.
REQ-026 Store without error SHALL commit wdata to storage on the rising edge ending the RESP cycle; resp_rdata=0 for stores.
REQ-027 Load without error SHALL drive resp_rdata with the stored word during RESP; any earlier committed store SHALL be visible.
REQ-028 resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.
REQ-029 busy SHALL be (state==WAIT) or (state==IDLE and req_valid=1); it is combinational and 0 in RESP, so the CPU advances on the response cycle.
REQ-030 Input changes after accept SHALL NOT affect the in-flight request.

Reset
REQ-031 Asserting reset_b=0 SHALL force state IDLE, counter 0, request register 0, and outputs req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
REQ-032 Reset during WAIT or RESP SHALL abort the request; a pending store SHALL NOT be committed.
REQ-033 Storage contents SHALL NOT be cleared by reset and SHALL be zero at simulation start.
REQ-034 The first accept SHALL be possible on the first rising edge after reset_b deasserts.

Verification
REQ-035 Use LATENCY=2. Store addr 0x10, data 0xDEADBEEF, accept at T -> busy=1 for cycles T..T+2, resp_valid=1 at T+3 with resp_err=0; a following load of 0x10 returns 0xDEADBEEF.
REQ-036 Load 0x13 (misaligned) -> resp_err=1, resp_rdata=0 at T+3. Store 0x1000 (out of range) -> resp_err=1, and a load of 0x0 remains unchanged.
REQ-037 req_valid held high continuously with alternating store/load -> accepts exactly every 4 cycles, one resp_valid pulse per accept, none lost or duplicated.
REQ-038 Store 0x20=0x12345678, reset_b pulsed low at T+1 -> no resp_valid, outputs at reset values, and a load of 0x20 returns 0x00000000.
REQ-039 LATENCY=0 build, load accepted at T -> resp_valid at T+1; back-to-back accepts every 2 cycles.
REQ-040 Change req_addr and req_wdata during WAIT -> the response reflects the captured values only.

Source files
------------

// File: rtl/dmem_resp_if.sv
// Memory-stage request/response bus between the CPU pipeline and the data-memory responder.
interface dmem_resp_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_resp.sv
// Single-outstanding data-memory responder: accepts one ld/sd, waits LATENCY cycles,
// then pulses a one-cycle response carrying load data or a fault flag.
module dmem_resp #(
  parameter int DMEM_DEPTH      = 1024,
  parameter int DMEM_ADDR_WIDTH = 10,
  parameter int LATENCY         = 2
) (
  input  logic        clk,
  input  logic        reset_b,
  dmem_resp_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [3:0]                 r_cnt;
  logic [3:0]                 w_cnt_nxt;
  logic                       r_write;
  logic [31:0]                r_addr;
  logic [31:0]                r_wdata;
  logic [31:0]                r_mem [DMEM_DEPTH] = '{default: '0};

  logic                       w_accept;
  logic                       w_err;
  logic [DMEM_ADDR_WIDTH-1:0] w_idx;
  logic [31:0]                w_rd_word;
  logic                       w_ready;
  logic                       w_resp_valid;
  logic [31:0]                w_resp_rdata;
  logic                       w_resp_err;
  logic                       w_busy;

  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:DMEM_ADDR_WIDTH+2] != '0);
  endfunction

  assign w_accept  = (r_state == IDLE) && bus.req_valid;
  assign w_idx     = r_addr[DMEM_ADDR_WIDTH+1:2];
  assign w_err     = addr_fault(r_addr);
  assign w_rd_word = r_mem[w_idx];

  // Stage: state, wait counter and captured request
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
    end
  end

  // Reset forces IDLE asynchronously, so an aborted store never reaches this commit.
  always_ff @(posedge clk) begin
    if ((r_state == RESP) && r_write && !w_err) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ready      = 1'b0;
    w_resp_valid = 1'b0;
    w_resp_rdata = 32'd0;
    w_resp_err   = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        w_busy  = bus.req_valid;
        if (bus.req_valid) begin
          if (LATENCY == 0) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        w_busy = 1'b1;
        if (r_cnt == 4'd0) begin
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        w_resp_valid = 1'b1;
        w_resp_err   = w_err;
        w_resp_rdata = (w_err || r_write) ? 32'd0 : w_rd_word;
        w_state_nxt  = IDLE;
        w_cnt_nxt    = 4'd0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_rdata = w_resp_rdata;
  assign bus.resp_err   = w_resp_err;
  // The stall must drop while reset is held even if the CPU still presents a request.
  assign bus.busy       = w_busy & reset_b;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: one LATENCY=2 and one LATENCY=0 instance share clock and reset.
module tb_dmem_resp;

  localparam int LAT [2] = '{2, 0};

  typedef struct {
    int          due;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  dmem_resp_if bus0 ();
  dmem_resp_if bus1 ();

  dmem_resp #(.DMEM_DEPTH(1024), .DMEM_ADDR_WIDTH(10), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset_b(rstb), .bus(bus0)
  );
  dmem_resp #(.DMEM_DEPTH(1024), .DMEM_ADDR_WIDTH(10), .LATENCY(0)) u_dut1 (
    .clk(clk), .reset_b(rstb), .bus(bus1)
  );

  logic        d_vld   [2];
  logic        d_wr    [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic        s_rdy   [2];
  logic        s_rvld  [2];
  logic [31:0] s_rdata [2];
  logic        s_err   [2];
  logic        s_busy  [2];

  assign bus0.req_valid = d_vld[0];
  assign bus0.req_write = d_wr[0];
  assign bus0.req_addr  = d_addr[0];
  assign bus0.req_wdata = d_wdata[0];
  assign bus1.req_valid = d_vld[1];
  assign bus1.req_write = d_wr[1];
  assign bus1.req_addr  = d_addr[1];
  assign bus1.req_wdata = d_wdata[1];

  assign s_rdy[0]   = bus0.req_ready;
  assign s_rvld[0]  = bus0.resp_valid;
  assign s_rdata[0] = bus0.resp_rdata;
  assign s_err[0]   = bus0.resp_err;
  assign s_busy[0]  = bus0.busy;
  assign s_rdy[1]   = bus1.req_ready;
  assign s_rvld[1]  = bus1.resp_valid;
  assign s_rdata[1] = bus1.resp_rdata;
  assign s_err[1]   = bus1.resp_err;
  assign s_busy[1]  = bus1.busy;

  exp_t        sq       [2][$];
  int          acc_hist [2][$];
  logic [31:0] mm       [2][1024];
  int          n_rsp    [2];
  int          n_vec = 0;
  int          n_bad = 0;
  int          ncyc  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
  endfunction

  task automatic mon_step(input int d);
    exp_t e;
    if (!rstb) begin
      sq[d].delete();
      return;
    end
    if (s_rvld[d]) begin
      n_rsp[d]++;
      check_eq($sformatf("d%0d_resp_expected", d), 64'(sq[d].size() != 0), 1);
      if (sq[d].size() != 0) begin
        e = sq[d].pop_front();
        check_eq($sformatf("d%0d_resp_cycle", d), 64'(ncyc), 64'(e.due));
        check_eq($sformatf("d%0d_rdata@%0h", d, e.addr), s_rdata[d], e.rdata);
        check_eq($sformatf("d%0d_err@%0h", d, e.addr), s_err[d], e.err);
        if (e.wr && !e.err) mm[d][e.addr[11:2]] = e.wdata;
      end
    end else begin
      check_eq($sformatf("d%0d_idle_outputs", d), {s_err[d], s_rdata[d]}, 0);
      if (sq[d].size() != 0 && sq[d][0].due <= ncyc) begin
        check_eq($sformatf("d%0d_resp_valid_due", d), s_rvld[d], 1);
        void'(sq[d].pop_front());
      end
    end
    if (d_vld[d] && s_rdy[d]) begin
      e.due   = ncyc + LAT[d] + 1;
      e.wr    = d_wr[d];
      e.addr  = d_addr[d];
      e.wdata = d_wdata[d];
      e.err   = fault(d_addr[d]);
      e.rdata = (e.err || e.wr) ? 32'd0 : mm[d][d_addr[d][11:2]];
      sq[d].push_back(e);
      acc_hist[d].push_back(ncyc);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon_step(d);
    ncyc++;
  end

  task automatic issue(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    d_vld[d] = 1'b1; d_wr[d] = wr; d_addr[d] = a; d_wdata[d] = wd;
    @(negedge clk);
    for (int i = 0; i < 20 && !s_rdy[d]; i++) @(negedge clk);
    check_eq($sformatf("d%0d_accept_ready", d), s_rdy[d], 1);
    check_eq($sformatf("d%0d_busy_on_request", d), s_busy[d], 1);
    @(posedge clk); #1;
    d_vld[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 40 && sq[d].size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check_eq($sformatf("d%0d_drain", d), 64'(sq[d].size()), 0);
  endtask

  task automatic stream(input int d, input int n);
    int rsp0;
    acc_hist[d].delete();
    rsp0 = n_rsp[d];
    @(posedge clk); #1;
    d_vld[d] = 1'b1;
    for (int k = 0; k < n; k++) begin
      d_wr[d]    = (k % 2 == 0);
      d_addr[d]  = 32'h100 + 32'(4 * (k / 2));
      d_wdata[d] = 32'hC0DE_0000 + 32'(k) + 32'(d << 8);
      @(negedge clk);
      for (int i = 0; i < 20 && !s_rdy[d]; i++) @(negedge clk);
      check_eq($sformatf("d%0d_stream_ready", d), s_rdy[d], 1);
      @(posedge clk); #1;
    end
    d_vld[d] = 1'b0;
    wait_idle(d);
    check_eq($sformatf("d%0d_stream_accepts", d), 64'(acc_hist[d].size()), 64'(n));
    for (int k = 1; k < acc_hist[d].size(); k++)
      check_eq($sformatf("d%0d_accept_gap%0d", d, k), 64'(acc_hist[d][k] - acc_hist[d][k-1]),
               64'(LAT[d] + 2));
    check_eq($sformatf("d%0d_stream_responses", d), 64'(n_rsp[d] - rsp0), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 1024; i++) mm[d][i] = 32'd0;
      n_rsp[d] = 0;
      d_vld[d] = 1'b0; d_wr[d] = 1'b0; d_addr[d] = 32'd0; d_wdata[d] = 32'd0;
    end
    // Reset held with a store already presented: outputs must sit at reset values.
    rstb = 1'b0;
    d_vld[0] = 1'b1; d_wr[0] = 1'b1; d_addr[0] = 32'h40; d_wdata[0] = 32'hA5A5_0001;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", s_rdy[0], 1);
    check_eq("rst_resp_valid", s_rvld[0], 0);
    check_eq("rst_rdata", s_rdata[0], 0);
    check_eq("rst_err", s_err[0], 0);
    check_eq("rst_busy", s_busy[0], 0);
    check_eq("rst_ready_d1", s_rdy[1], 1);
    @(posedge clk); #1;
    rstb = 1'b1;
    @(posedge clk); #1;
    check_eq("first_edge_accept", s_rdy[0], 0);
    d_vld[0] = 1'b0;
    wait_idle(0);

    // Store then load with busy/latency profile at LATENCY=2.
    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk); check_eq("busy_T+1", s_busy[0], 1);
    @(negedge clk); check_eq("busy_T+2", s_busy[0], 1);
    @(negedge clk); check_eq("busy_T+3", s_busy[0], 0);
    check_eq("resp_T+3", s_rvld[0], 1);
    check_eq("err_T+3", s_err[0], 0);
    wait_idle(0);
    issue(0, 1'b0, 32'h10, 32'h0);   wait_idle(0);
    issue(0, 1'b0, 32'h40, 32'h0);   wait_idle(0);

    // Faulting accesses leave storage untouched.
    issue(0, 1'b0, 32'h13, 32'h0);           wait_idle(0);
    issue(0, 1'b1, 32'h1000, 32'h0BAD_0BAD); wait_idle(0);
    issue(0, 1'b0, 32'h0, 32'h0);            wait_idle(0);
    issue(0, 1'b1, 32'h8000_0000, 32'h1);    wait_idle(0);
    issue(0, 1'b0, 32'h0, 32'h0);            wait_idle(0);

    // Continuous requests alternating store/load.
    stream(0, 10);

    // Reset pulsed in WAIT aborts the store.
    issue(0, 1'b1, 32'h20, 32'h1234_5678);
    rstb = 1'b0;
    @(negedge clk);
    check_eq("abort_ready", s_rdy[0], 1);
    check_eq("abort_busy", s_busy[0], 0);
    check_eq("abort_outputs", {s_rvld[0], s_err[0], s_rdata[0]}, 0);
    repeat (3) begin
      @(negedge clk); check_eq("abort_no_resp", s_rvld[0], 0);
    end
    @(posedge clk); #1;
    rstb = 1'b1;
    issue(0, 1'b0, 32'h20, 32'h0); wait_idle(0);

    // Reset landing inside the RESP cycle also suppresses the commit.
    issue(0, 1'b1, 32'h24, 32'h5555_AAAA);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("resp_before_reset", s_rvld[0], 1);
    rstb = 1'b0;
    #1;
    check_eq("resp_killed_by_reset", s_rvld[0], 0);
    @(posedge clk); #1;
    rstb = 1'b1;
    issue(0, 1'b0, 32'h24, 32'h0); wait_idle(0);

    // Inputs changed during WAIT must not leak into the in-flight request.
    issue(0, 1'b1, 32'h30, 32'h1111_2222);
    d_addr[0] = 32'h34; d_wdata[0] = 32'hFFFF_FFFF; d_wr[0] = 1'b0;
    wait_idle(0);
    issue(0, 1'b0, 32'h30, 32'h0);
    d_addr[0] = 32'h13;
    wait_idle(0);
    issue(0, 1'b0, 32'h34, 32'h0); wait_idle(0);

    // LATENCY=0 instance: response the cycle after accept, accepts every 2 cycles.
    issue(1, 1'b1, 32'h10, 32'h7777_0001);
    @(negedge clk); check_eq("d1_resp_T+1", s_rvld[1], 1);
    wait_idle(1);
    issue(1, 1'b0, 32'h10, 32'h0);
    @(negedge clk); check_eq("d1_load_T+1", s_rvld[1], 1);
    wait_idle(1);
    issue(1, 1'b0, 32'h2, 32'h0); wait_idle(1);
    stream(1, 8);

    repeat (3) @(negedge clk);
    check_eq("final_q0_empty", 64'(sq[0].size()), 0);
    check_eq("final_q1_empty", 64'(sq[1].size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
